// File: rtl/ddr2_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_rw_arbiter
// Description : Refresh > read > write command arbiter for the DDR2 core port,
//               with bounded write starvation and RD<->WR turnaround gaps.
//               Optional write aging: define DDR2_ARB_AGING_EN.
// Revision    : 1.0
// ============================================================================
module ddr2_rw_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int LEN_WIDTH     = 8,
    parameter int TURNAROUND    = 2,
    parameter int MAX_RD_STREAK = 4,
    parameter int WR_AGE_LIMIT  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [LEN_WIDTH-1:0]  wr_len,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [LEN_WIDTH-1:0]  rd_len,
    input  logic                  ref_req,
    output logic                  ref_ack,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [1:0]            cmd_type,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_TURN  = 2'd1;
    localparam logic [1:0] c_ST_GRANT = 2'd2;

    localparam logic [1:0] c_CMD_NONE = 2'b00;
    localparam logic [1:0] c_CMD_RD   = 2'b01;
    localparam logic [1:0] c_CMD_WR   = 2'b10;
    localparam logic [1:0] c_CMD_REF  = 2'b11;

    localparam logic c_DIR_RD = 1'b0;
    localparam logic c_DIR_WR = 1'b1;

    localparam int c_TW = (TURNAROUND > 1) ? $clog2(TURNAROUND + 1) : 1;
    localparam int c_SW = (MAX_RD_STREAK > 0) ? $clog2(MAX_RD_STREAK + 1) : 1;

    logic [1:0]            r_state;
    logic                  r_last_dir;
    logic [c_TW-1:0]       r_turn_cnt;
    logic [c_SW-1:0]       r_rd_streak;
    logic [1:0]            r_cmd_type;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [LEN_WIDTH-1:0]  r_cmd_len;
    logic                  r_ref_ack;

    logic w_idle;
    logic w_aged;
    logic w_wr_wins;
    logic w_ref_go;
    logic w_wr_go;
    logic w_rd_go;
    logic w_new_dir;
    logic w_turn;
    logic w_wr_grant;
    logic w_rd_grant;

`ifdef DDR2_ARB_AGING_EN
    localparam int c_AW = (WR_AGE_LIMIT > 0) ? $clog2(WR_AGE_LIMIT + 1) : 1;

    logic [c_AW-1:0] r_wr_age;

    // Saturating at the limit is enough: only the >= comparison is observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_age <= '0;
        end else if (!wr_valid || w_wr_grant) begin
            r_wr_age <= '0;
        end else if (r_wr_age != c_AW'(WR_AGE_LIMIT)) begin
            r_wr_age <= r_wr_age + c_AW'(1);
        end
    end

    assign w_aged = (r_wr_age >= c_AW'(WR_AGE_LIMIT));
`else
    // Aging disabled: the limit can never force a write.
    assign w_aged = (WR_AGE_LIMIT < 0);
`endif

    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_wr_wins  = wr_valid && (!rd_valid || (r_rd_streak == c_SW'(MAX_RD_STREAK)) || w_aged);
    assign w_ref_go   = w_idle && ref_req;
    assign w_wr_go    = w_idle && !ref_req && w_wr_wins;
    assign w_rd_go    = w_idle && !ref_req && !w_wr_wins && rd_valid;
    assign w_new_dir  = w_wr_go ? c_DIR_WR : c_DIR_RD;
    assign w_turn     = (TURNAROUND != 0) && (w_new_dir != r_last_dir);
    assign w_wr_grant = w_wr_go && !w_turn;
    assign w_rd_grant = w_rd_go && !w_turn;

    // Ready is combinational, so it is gated by rst_n to stay low during reset.
    assign wr_ready  = rst_n && w_wr_grant;
    assign rd_ready  = rst_n && w_rd_grant;
    assign ref_ack   = r_ref_ack;
    assign cmd_valid = (r_state == c_ST_GRANT);
    assign cmd_type  = r_cmd_type;
    assign cmd_addr  = r_cmd_addr;
    assign cmd_len   = r_cmd_len;
    assign busy      = !w_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_last_dir <= c_DIR_RD;
            r_turn_cnt <= '0;
            r_cmd_type <= c_CMD_NONE;
            r_cmd_addr <= '0;
            r_cmd_len  <= '0;
            r_ref_ack  <= 1'b0;
        end else begin
            r_ref_ack <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_ref_go) begin
                        r_cmd_type <= c_CMD_REF;
                        r_cmd_addr <= '0;
                        r_cmd_len  <= '0;
                        r_state    <= c_ST_GRANT;
                    end else if (w_wr_go || w_rd_go) begin
                        r_last_dir <= w_new_dir;
                        if (w_turn) begin
                            r_turn_cnt <= c_TW'(TURNAROUND);
                            r_state    <= c_ST_TURN;
                        end else begin
                            r_cmd_type <= w_wr_go ? c_CMD_WR : c_CMD_RD;
                            r_cmd_addr <= w_wr_go ? wr_addr : rd_addr;
                            r_cmd_len  <= w_wr_go ? wr_len : rd_len;
                            r_state    <= c_ST_GRANT;
                        end
                    end
                end
                c_ST_TURN: begin
                    r_turn_cnt <= r_turn_cnt - c_TW'(1);
                    if (r_turn_cnt <= c_TW'(1)) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_GRANT: begin
                    if (cmd_ready) begin
                        r_ref_ack  <= (r_cmd_type == c_CMD_REF);
                        r_cmd_type <= c_CMD_NONE;
                        r_cmd_addr <= '0;
                        r_cmd_len  <= '0;
                        r_state    <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_streak <= '0;
        end else if (!wr_valid || w_wr_grant) begin
            r_rd_streak <= '0;
        end else if (w_rd_grant && (r_rd_streak != c_SW'(MAX_RD_STREAK))) begin
            r_rd_streak <= r_rd_streak + c_SW'(1);
        end
    end

endmodule
`default_nettype wire
